// File: rtl/bcd_pkg.sv
// Shared BCD constants, types and helpers used by the multi-digit counter
// and its single-digit cell.
package bcd_pkg;

   localparam int unsigned BCD_W = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
   localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

   typedef logic [BCD_W-1:0] bcd_nibble_t;

   // Operation selected for the current edge after priority resolution.
   typedef enum logic [2:0] {
      OpHold,
      OpClear,
      OpLoad,
      OpLoadReject,
      OpStep
   } bcd_op_e;

   function automatic logic bcd_valid(input bcd_nibble_t nibble);
      return nibble <= BCD_MAX;
   endfunction

   function automatic logic bcd_terminal(input bcd_nibble_t nibble, input logic up_dn);
      return up_dn ? (nibble == BCD_MAX) : (nibble == BCD_MIN);
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit cell: computes the stepped value of one digit and the
// carry/borrow it passes to the next more-significant digit.
module bcd_digit
   import bcd_pkg::*;
(
   input  logic              up_dn,
   input  logic              cin,
   input  logic [BCD_W-1:0]  value,
   output logic [BCD_W-1:0]  next_val,
   output logic              cout
);

   logic terminal;

   assign terminal = bcd_terminal(value, up_dn);
   assign cout     = cin & terminal;

   always_comb begin
      next_val = value;
      if (cin) begin
         if (up_dn) begin
            next_val = terminal ? BCD_MIN : value + 4'd1;
         end else begin
            next_val = terminal ? BCD_MAX : value - 4'd1;
         end
      end
   end

endmodule

// File: rtl/bcd_counter_multi.sv
// Parametrised N-digit BCD up/down counter with validated parallel load,
// synchronous clear, wrap/saturate mode and a combinational cascade carry.
module bcd_counter_multi
   import bcd_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter bit          WRAP       = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable,
   input  logic                        up_dn,
   input  logic                        clear,
   input  logic                        load,
   input  logic [BCD_W*NUM_DIGITS-1:0] load_val,
   output logic [BCD_W*NUM_DIGITS-1:0] bcd_out,
   output logic                        carry_out,
   output logic                        load_err
);

   localparam int unsigned W = BCD_W * NUM_DIGITS;

   logic [W-1:0]          count_q, count_d;
   logic [W-1:0]          step_val;
   logic [NUM_DIGITS:0]   chain;
   logic                  terminal;
   logic                  load_ok;
   logic                  load_err_d;
   bcd_op_e               op;

   // Digit 0 always receives a step request; the chain then ripples the
   // carry/borrow, so chain[NUM_DIGITS] is the whole-counter terminal flag.
   assign chain[0] = 1'b1;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
         .up_dn    (up_dn),
         .cin      (chain[g]),
         .value    (count_q[g*BCD_W +: BCD_W]),
         .next_val (step_val[g*BCD_W +: BCD_W]),
         .cout     (chain[g+1])
      );
   end

   assign terminal = chain[NUM_DIGITS];

   always_comb begin
      load_ok = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!bcd_valid(load_val[i*BCD_W +: BCD_W])) begin
            load_ok = 1'b0;
         end
      end
   end

   always_comb begin
      op = OpHold;
      if (clear) begin
         op = OpClear;
      end else if (load) begin
         op = load_ok ? OpLoad : OpLoadReject;
      end else if (enable) begin
         op = OpStep;
      end
   end

   always_comb begin
      count_d    = count_q;
      load_err_d = 1'b0;
      unique case (op)
         OpClear:      count_d = '0;
         OpLoad:       count_d = load_val;
         OpLoadReject: load_err_d = 1'b1;
         OpStep: begin
            // In saturate mode the terminal value is held instead of rolling over.
            if (WRAP || !terminal) begin
               count_d = step_val;
            end
         end
         default:      count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q  <= '0;
         load_err <= 1'b0;
      end else begin
         count_q  <= count_d;
         load_err <= load_err_d;
      end
   end

   assign bcd_out   = count_q;
   assign carry_out = enable & ~clear & ~load & terminal;

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Directed, table-driven bench for bcd_counter_multi (4 digits), with a
// wrapping instance and a saturating instance sharing the same stimulus.
module tb_bcd_counter_multi;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        up_dn;
   logic        clear;
   logic        load;
   logic [15:0] load_val;
   logic [15:0] bcd_w, bcd_s;
   logic        carry_w, carry_s;
   logic        err_w, err_s;

   int total_cnt = 0;
   int pass_cnt  = 0;

   bcd_counter_multi #(.NUM_DIGITS(4), .WRAP(1'b1)) u_dut_wrap (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .up_dn     (up_dn),
      .clear     (clear),
      .load      (load),
      .load_val  (load_val),
      .bcd_out   (bcd_w),
      .carry_out (carry_w),
      .load_err  (err_w)
   );

   bcd_counter_multi #(.NUM_DIGITS(4), .WRAP(1'b0)) u_dut_sat (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .up_dn     (up_dn),
      .clear     (clear),
      .load      (load),
      .load_val  (load_val),
      .bcd_out   (bcd_s),
      .carry_out (carry_s),
      .load_err  (err_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        clr;
      logic        ld;
      logic        en;
      logic        up;
      logic [15:0] lv;
      logic        exp_carry;  // carry_out before the edge
      logic [15:0] exp_bcd;    // bcd_out after the edge
      logic        exp_err;    // load_err after the edge
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic clr, input logic ld, input logic en, input logic up,
                               input logic [15:0] lv, input logic c, input logic [15:0] b,
                               input logic e);
      vec_t v;
      v.clr = clr; v.ld = ld; v.en = en; v.up = up; v.lv = lv;
      v.exp_carry = c; v.exp_bcd = b; v.exp_err = e;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) begin
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end else begin
         pass_cnt++;
      end
   endtask

   task automatic drive(input logic clr, input logic ld, input logic en, input logic up,
                        input logic [15:0] lv);
      clear    = clr;
      load     = ld;
      enable   = en;
      up_dn    = up;
      load_val = lv;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
      #3;
      check("reset_bcd", {16'h0, bcd_w}, 32'h0000);
      check("reset_err", {31'h0, err_w}, 32'h0);
      tick();
      rst = 1'b1;

      // Count to 0042, then assert reset between edges.
      drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0040);
      tick();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
      tick();
      tick();
      check("pre_reset_bcd", {16'h0, bcd_w}, 32'h0042);
      #2;
      rst = 1'b0;
      #1;
      check("async_reset_bcd", {16'h0, bcd_w}, 32'h0000);
      check("async_reset_err", {31'h0, err_w}, 32'h0);
      #1;
      rst = 1'b1;
      tick();
      check("post_reset_step", {16'h0, bcd_w}, 32'h0001);

      // Table of single-edge vectors for the wrapping instance, starting at 0001.
      vecs.push_back(mk(0, 1, 0, 1, 16'h9998, 0, 16'h9998, 0));
      vecs.push_back(mk(0, 0, 1, 1, 16'h0000, 0, 16'h9999, 0));
      vecs.push_back(mk(0, 0, 1, 1, 16'h0000, 1, 16'h0000, 0));
      vecs.push_back(mk(0, 0, 1, 1, 16'h0000, 0, 16'h0001, 0));
      vecs.push_back(mk(0, 1, 0, 0, 16'h1000, 0, 16'h1000, 0));
      vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 16'h0999, 0));
      vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0));
      vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 1, 16'h9999, 0));
      vecs.push_back(mk(0, 1, 0, 1, 16'h0199, 0, 16'h0199, 0));
      vecs.push_back(mk(0, 0, 1, 1, 16'h0000, 0, 16'h0200, 0));
      vecs.push_back(mk(0, 1, 0, 0, 16'h0100, 0, 16'h0100, 0));
      vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 16'h0099, 0));
      vecs.push_back(mk(0, 1, 0, 1, 16'h0123, 0, 16'h0123, 0));
      vecs.push_back(mk(0, 1, 0, 1, 16'h12A4, 0, 16'h0123, 1));
      vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 0, 16'h0123, 0));
      vecs.push_back(mk(0, 1, 0, 1, 16'h5678, 0, 16'h5678, 0));
      vecs.push_back(mk(0, 1, 0, 1, 16'hA000, 0, 16'h5678, 1));
      vecs.push_back(mk(0, 1, 0, 1, 16'h0456, 0, 16'h0456, 0));
      vecs.push_back(mk(1, 1, 1, 1, 16'h0999, 0, 16'h0000, 0));
      vecs.push_back(mk(0, 1, 1, 1, 16'h0777, 0, 16'h0777, 0));
      vecs.push_back(mk(0, 0, 1, 1, 16'h0000, 0, 16'h0778, 0));
      vecs.push_back(mk(0, 1, 0, 1, 16'h9999, 0, 16'h9999, 0));
      vecs.push_back(mk(0, 1, 1, 1, 16'h9999, 0, 16'h9999, 0));
      vecs.push_back(mk(0, 1, 1, 1, 16'h999F, 0, 16'h9999, 1));
      vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 16'h9998, 0));
      vecs.push_back(mk(1, 0, 0, 1, 16'h0000, 0, 16'h0000, 0));
      vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0));

      foreach (vecs[i]) begin
         drive(vecs[i].clr, vecs[i].ld, vecs[i].en, vecs[i].up, vecs[i].lv);
         #1;
         check($sformatf("vec%0d_carry", i), {31'h0, carry_w}, {31'h0, vecs[i].exp_carry});
         tick();
         check($sformatf("vec%0d_bcd", i), {16'h0, bcd_w}, {16'h0, vecs[i].exp_bcd});
         check($sformatf("vec%0d_err", i), {31'h0, err_w}, {31'h0, vecs[i].exp_err});
      end

      // Saturating instance: hold at 9999 counting up, carry stays high.
      drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h9999);
      tick();
      check("sat_load", {16'h0, bcd_s}, 32'h9999);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("sat_carry%0d", k), {31'h0, carry_s}, 32'h1);
         tick();
         check($sformatf("sat_hold%0d", k), {16'h0, bcd_s}, 32'h9999);
      end
      check("sat_err", {31'h0, err_s}, 32'h0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      #1;
      check("sat_down_carry", {31'h0, carry_s}, 32'h0);
      tick();
      check("sat_down", {16'h0, bcd_s}, 32'h9998);

      // Saturating instance at 0000 counting down holds.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      tick();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      #1;
      check("sat_zero_carry", {31'h0, carry_s}, 32'h1);
      tick();
      check("sat_zero_hold", {16'h0, bcd_s}, 32'h0000);

      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
      tick();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/bcd_counter_multi.md
Name: bcd_counter_multi

Overview:
Parametrised multi-digit BCD counter; next generation of the single-digit bcd_counter.
Adds N-digit width, up/down counting, synchronous parallel load with BCD validity check, synchronous clear, wrap/saturate mode and a cascade carry/borrow output.
Sits in the sequence-generator area as a timebase/event counter that feeds decimal displays and chains into further counters.

Parameters:
NUM_DIGITS, 4, number of BCD digits; legal range 1..8.
WRAP, 1, 1 = wrap at terminal count (9999->0000 up, 0000->9999 down); 0 = saturate (hold) at terminal.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
enable  input  1  count enable; one step per clk edge while high.
up_dn  input  1  1 = count up, 0 = count down; sampled each cycle.
clear  input  1  synchronous clear to all zeros.
load  input  1  synchronous parallel load request.
load_val  input  4*NUM_DIGITS  BCD value to load; digit 0 in [3:0].
bcd_out  output  4*NUM_DIGITS  registered count; digit 0 in [3:0].
carry_out  output  1  combinational cascade pulse: enable high and count at terminal for the current direction.
load_err  output  1  registered one-cycle pulse: load rejected because a nibble was invalid.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst=0, bcd_out = 0 and load_err = 0 immediately, regardless of clk. carry_out follows its equation.
- Release of rst is synchronous in effect: the first count can occur on the first clk edge that sees rst=1.
- Priority on each edge: clear > load > enable. Lower-priority requests in the same cycle are ignored.
- clear=1: bcd_out <= 0 and load_err <= 0.
- load=1 with every nibble of load_val <= 9: bcd_out <= load_val and load_err <= 0.
- load=1 with any nibble > 9: bcd_out holds, load_err <= 1 for exactly one cycle, and no count occurs that cycle.
- enable=1 with no clear or load: the counter steps by 1 in the up_dn direction. Otherwise it holds.
- Up step: digit 0 increments. A digit at 9 goes to 0 and carries into the next digit.
- Down step: digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit.
- Terminal count: all digits 9 when counting up; all digits 0 when counting down.
- At terminal with WRAP=1: the counter rolls over (all 9s -> all 0s, or all 0s -> all 9s).
- At terminal with WRAP=0: the counter holds its value.
- carry_out = enable & ~clear & ~load & terminal(up_dn). It is asserted in the same cycle the rollover edge arrives, so a downstream counter's enable can be tied directly to carry_out.
- Invariant: every digit of bcd_out is always 0..9. No A-F state is reachable, including after a rejected load.
- up_dn changing between cycles takes effect on the next edge. No extra latency and no glitch in bcd_out.
- load_err is cleared on every edge that has no invalid load.
- Latency: 1 clk from input to bcd_out; 0 cycles for carry_out.

Decomposition:
- Shared package bcd_pkg holds:
  - BCD_W = 4
  - BCD_MAX = 4'd9
  - BCD_MIN = 4'd0
  - function bcd_valid(nibble)
- One sub-module, bcd_digit: a single-digit cell.
  - Inputs: up_dn, cin (step request), current value.
  - Outputs: next value, cout (terminal & cin).
- Top level instantiates NUM_DIGITS bcd_digit cells with a generate loop, chaining cin/cout. It also owns the registers, the priority logic, load validation and the WRAP handling.

Test Plan:
- Reset mid-count: count to 0042, drop rst between edges -> bcd_out=0000 immediately. Release rst, enable=1 up -> 0001 on the next edge.
- Up rollover, WRAP=1: load 9998, enable up for 3 edges -> 9999, 0000, 0001. carry_out=1 only while the value is 9999.
- Down borrow, WRAP=1: load 1000, enable down -> 0999. Load 0000, step down -> 9999 with carry_out=1 in the preceding cycle.
- Saturate, WRAP=0: load 9999, up, 5 edges -> stays 9999, carry_out stays 1. Switch to down -> 9998.
- Invalid load: bcd_out=0123, load_val=0x12A4 -> bcd_out stays 0123, load_err=1 for one cycle then 0. Valid load 0x5678 -> 5678, load_err=0.
- Priority: clear=load=enable=1 with value 0456 -> 0000. Then load=enable=1 with load_val=0777 -> 0777, no increment.
